clk_div_meas: RTL and testbench
===============================

// Module: clk_div_meas
// PURPOSE
// - Receive end of the divided-clock path: measures an incoming slow clock against clk_i.
// - Reports high-phase, low-phase and period lengths in clk_i cycles, plus stability and stop status.
// - Sits beside clock generators to check divider settings at runtime and in bring-up.
// PARAMETERS
// - DIV_WIDTH    4            width of divider settings under check; sizes default CNT_WIDTH
// - CNT_WIDTH    DIV_WIDTH+2  phase counter width; max phase = 2**CNT_WIDTH-1 cycles
// - SYNC_STAGES  2            flops in the div_clk_i synchronizer (>=2); used only with macro
// PORTS
// - clk_i      in   1            measurement clock; all logic on rising edge
// - arst_i     in   1            asynchronous reset, active-high
// - div_clk_i  in   1            clock under measurement; async to clk_i when macro defined
// - high_o     out  CNT_WIDTH    last complete high-phase length, clk_i cycles
// - low_o      out  CNT_WIDTH    last complete low-phase length, clk_i cycles
// - period_o   out  CNT_WIDTH+1  high_o + low_o, zero-extended, no truncation
// - valid_o    out  1            1-cycle pulse: high_o/low_o/period_o updated this cycle
// - stable_o   out  1            last two periods had identical high_o and low_o
// - stopped_o  out  1            no edge within max phase length; sticky until next valid_o
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, counter 0, sync flops 0; async assert, sync release.
// - s = synchronized div_clk_i; s_d = s delayed 1 cycle; rise = s&~s_d, fall = ~s&s_d.
// - FSM IDLE: ignore partial phase; on rise -> HIGH, cnt=1.
// - HIGH: cnt++ each cycle; on fall -> latch hi_tmp=cnt, cnt=1 -> LOW.
// - LOW: cnt++ each cycle; on rise -> high_o=hi_tmp, low_o=cnt,
//   period_o=hi_tmp+cnt, valid_o=1 next cycle, cnt=1 -> HIGH.
// - Phase counts are exact: a level held N clk_i samples gives count N (min 1).
// - First valid_o needs one full high and one full low phase after leaving IDLE.
// - stable_o updates only with valid_o: 1 if new high/low equal previous, else 0.
//   First measurement after IDLE always gives stable_o=0.
// - Timeout: in HIGH/LOW, if cnt==2**CNT_WIDTH-1 and no edge this cycle:
//   stopped_o=1, stable_o=0, FSM -> IDLE, outputs hold old values, no valid_o.
// - Edge and saturation in same cycle: edge wins, normal measurement, no stop.
// - stopped_o clears in the same cycle valid_o next pulses.
// - Glitch of one sample: counts as two edges; phases of length 1 are legal.
// - Latency: div_clk_i rise sampled at clk_i edge k -> valid_o high at edge k+SYNC_STAGES+2.
// - Reset mid-measurement: partial counts discarded; measurement restarts from IDLE.
// CONFIGURATION
// - Macro CLK_DIV_MEAS_SYNC_EN.
// - Defined: SYNC_STAGES-flop synchronizer on div_clk_i; safe for asynchronous input.
// - Undefined: single capture flop (SYNC_STAGES treated as 1); caller guarantees
//   div_clk_i is synchronous to clk_i; valid_o latency = k+3; all else identical.
// TESTING
// - Toggle div_clk_i every 3 clk_i cycles (macro on) -> high_o=3, low_o=3, period_o=6.
//   Same case: valid_o every 6 cycles; stable_o=0 on 1st valid, 1 from 2nd.
// - Duty 2 high / 5 low -> high_o=2, low_o=5, period_o=7.
//   Then switch to 4/4 -> first valid gives stable_o=0, next gives stable_o=1.
// - Hold div_clk_i high after lock, CNT_WIDTH=6 -> stopped_o=1 after 63 cycles in HIGH.
//   Same case: valid_o stays 0, stable_o=0, old values held; restart 3/3 -> stopped_o clears at next valid.
// - Assert arst_i mid-LOW phase -> all outputs 0 immediately.
//   After release, first valid_o only after a full rise-fall-rise sequence.
// - Edge on the cycle cnt reaches 63 (CNT_WIDTH=6) -> valid_o with the phase = 63, stopped_o stays 0.
// - Macro off, div_clk_i synchronous 1 high/1 low -> high_o=1, low_o=1, period_o=2.
//   Same case: valid_o 3 cycles after the sampled rise.

Source files
------------

// File: rtl/clk_div_meas.sv
// clk_div_meas: measures high/low/period of div_clk_i in clk_i cycles, with stability and stop status.
// Macro CLK_DIV_MEAS_SYNC_EN selects a SYNC_STAGES-flop synchronizer instead of a single capture flop.
module clk_div_meas #(
  parameter int DIV_WIDTH = 4,
  parameter int CNT_WIDTH = DIV_WIDTH + 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic                 div_clk_i,
  output logic [CNT_WIDTH-1:0] high_o,
  output logic [CNT_WIDTH-1:0] low_o,
  output logic [CNT_WIDTH:0]   period_o,
  output logic                 valid_o,
  output logic                 stable_o,
  output logic                 stopped_o
);
`ifdef CLK_DIV_MEAS_SYNC_EN
  localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
`else
  localparam int NS = 1 + 0 * SYNC_STAGES;
`endif
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  state_t state_q, state_d;
  logic [1:0] rst_q;
  logic rst;
  logic [NS-1:0] sync_q;
  logic s, s_d_q, rise_q, fall_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, hi_q, hi_d, lo_q, lo_d;
  logic pend_q, pend_d, timeout, prev_ok_q;
  logic [CNT_WIDTH-1:0] high_q, low_q;
  logic [CNT_WIDTH:0] period_q;
  logic valid_q, stable_q, stopped_q;
  // reset asserts immediately but releases on a clk_i edge
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) rst_q <= 2'b11;
    else rst_q <= {rst_q[0], 1'b0};
  assign rst = rst_q[1];
  assign s = sync_q[NS-1];
  always_ff @(posedge clk_i or posedge rst)
    if (rst) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= NS'({sync_q, div_clk_i});
      s_d_q  <= s;
      rise_q <= s & ~s_d_q;
      fall_q <= ~s & s_d_q;
    end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_ONE;
    hi_d    = hi_q;
    lo_d    = lo_q;
    pend_d  = 1'b0;
    timeout = 1'b0;
    if (state_q == IDLE) begin
      cnt_d   = rise_q ? CNT_ONE : '0;
      state_d = rise_q ? HIGH : IDLE;
    end else if (state_q == HIGH && fall_q) begin
      hi_d    = cnt_q;
      cnt_d   = CNT_ONE;
      state_d = LOW;
    end else if (state_q == LOW && rise_q) begin
      lo_d    = cnt_q;
      pend_d  = 1'b1;
      cnt_d   = CNT_ONE;
      state_d = HIGH;
    end else if (cnt_q == CNT_MAX) begin
      timeout = 1'b1;
      cnt_d   = '0;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_i or posedge rst)
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_q    <= 1'b0;
      prev_ok_q <= 1'b0;
      high_q    <= '0;
      low_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      stable_q  <= 1'b0;
      stopped_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      pend_q  <= pend_d;
      valid_q <= pend_q;
      if (pend_q) begin
        high_q    <= hi_q;
        low_q     <= lo_q;
        period_q  <= {1'b0, hi_q} + {1'b0, lo_q};
        stable_q  <= prev_ok_q && hi_q == high_q && lo_q == low_q;
        stopped_q <= 1'b0;
        prev_ok_q <= 1'b1;
      end else if (timeout) begin
        stable_q  <= 1'b0;
        stopped_q <= 1'b1;
        prev_ok_q <= 1'b0;
      end
    end
  assign high_o    = high_q;
  assign low_o     = low_q;
  assign period_o  = period_q;
  assign valid_o   = valid_q;
  assign stable_o  = stable_q;
  assign stopped_o = stopped_q;
endmodule

// File: tb/tb_clk_div_meas.sv
// tb_clk_div_meas: directed table of duty patterns plus hand sequences for latency, timeout, saturation and reset.
module tb_clk_div_meas;
  localparam int CW = 6;
`ifdef CLK_DIV_MEAS_SYNC_EN
  localparam int L = 4;
`else
  localparam int L = 3;
`endif
  typedef struct {
    int hi, lo, reps;
    int e_hi, e_lo, e_per, e_stb, e_gap;
  } vec_t;
  logic clk = 1'b0, arst = 1'b1, div = 1'b0;
  logic [CW-1:0] high, low;
  logic [CW:0] period;
  logic valid, stable, stopped;
  int checks = 0, errors = 0;
  int cyc = 0, vcount = 0, vcyc = 0, vgap = 0;
  vec_t tv [7];
  clk_div_meas dut (
    .clk_i(clk), .arst_i(arst), .div_clk_i(div),
    .high_o(high), .low_o(low), .period_o(period),
    .valid_o(valid), .stable_o(stable), .stopped_o(stopped)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (valid === 1'b1) begin
      vgap   <= cyc - vcyc;
      vcyc   <= cyc;
      vcount <= vcount + 1;
    end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic phase(input logic lvl, input int n);
    div = lvl;
    repeat (n) @(negedge clk);
  endtask
  task automatic chk_res(input string tag, input int h, input int l, input int p, input int st);
    chk({tag, "_high"}, 32'(high), h);
    chk({tag, "_low"}, 32'(low), l);
    chk({tag, "_period"}, 32'(period), p);
    chk({tag, "_stable"}, 32'(stable), st);
  endtask
  initial begin
    int rc, vc;
    tv[0] = '{3, 3, 4, 3, 3, 6, 1, 6};
    tv[1] = '{2, 5, 3, 2, 5, 7, 1, 7};
    tv[2] = '{4, 4, 2, 4, 4, 8, 0, 8};
    tv[3] = '{4, 4, 2, 4, 4, 8, 1, 8};
    tv[4] = '{1, 1, 6, 1, 1, 2, 1, 2};
    tv[5] = '{1, 6, 3, 1, 6, 7, 1, 7};
    tv[6] = '{7, 2, 3, 7, 2, 9, 1, 9};
    repeat (3) @(negedge clk);
    chk_res("rst", 0, 0, 0, 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_stopped", 32'(stopped), 0);
    arst = 1'b0;
    phase(0, 4);
    phase(1, 3);
    phase(0, 3);
    div = 1'b1;
    rc = cyc + 1;
    repeat (3) @(negedge clk);
    phase(0, 3);
    #1;
    chk("first_vcount", vcount, 1);
    chk("first_latency", vcyc - rc, L);
    chk_res("first", 3, 3, 6, 0);
    for (int i = 0; i < 7; i++) begin
      for (int r = 0; r < tv[i].reps; r++) begin
        phase(1, tv[i].hi);
        phase(0, tv[i].lo);
      end
      #1;
      chk_res($sformatf("v%0d", i), tv[i].e_hi, tv[i].e_lo, tv[i].e_per, tv[i].e_stb);
      chk($sformatf("v%0d_gap", i), vgap, tv[i].e_gap);
    end
    phase(1, 10);
    #1;
    vc = vcount;
    chk_res("pre_stop", 7, 2, 9, 1);
    phase(1, 60);
    #1;
    chk("stop_stopped", 32'(stopped), 1);
    chk_res("stop_hold", 7, 2, 9, 0);
    chk("stop_novalid", vcount, vc);
    phase(0, 3);
    #1;
    chk("stop_sticky", 32'(stopped), 1);
    phase(1, 3);
    phase(0, 3);
    phase(1, 3);
    phase(0, 3);
    #1;
    chk("restart_stopped", 32'(stopped), 0);
    chk_res("restart", 3, 3, 6, 0);
    phase(1, 63);
    phase(0, 4);
    phase(1, 4);
    phase(0, 4);
    #1;
    chk("sat_stopped", 32'(stopped), 0);
    chk_res("sat", 63, 4, 67, 0);
    phase(0, 2);
    #3;
    arst = 1'b1;
    #1;
    chk_res("arst", 0, 0, 0, 0);
    chk("arst_valid", 32'(valid), 0);
    chk("arst_stopped", 32'(stopped), 0);
    @(negedge clk);
    repeat (2) @(negedge clk);
    arst = 1'b0;
    phase(0, 4);
    vc = vcount;
    phase(1, 3);
    phase(0, 3);
    phase(1, 3);
    #1;
    chk("post_rst_novalid", vcount, vc);
    phase(0, 3);
    #1;
    chk("post_rst_vcount", vcount, vc + 1);
    chk_res("post_rst", 3, 3, 6, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
